vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 93 +++++++++
 tb/tb_vga_timing.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters, frame count,
// registered sync/visible outputs aligned to the position outputs.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  position_x,
  output logic [9:0]  position_x_NEXT,
  output logic [8:0]  position_y,
  output logic [8:0]  position_y_NEXT,
  output logic [31:0] frame,
  output logic        hsync,
  output logic        vsync,
  output logic        visible
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  r_hcount;
  logic [9:0]  r_vcount;
  logic [31:0] r_frame;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_visible;

  logic [9:0]  w_hnext;
  logic [9:0]  w_vnext;
  logic        w_hwrap;
  logic        w_vwrap;

  assign w_hwrap = (r_hcount == H_LAST);
  assign w_vwrap = (r_vcount == V_LAST);

  // Lookahead reads as (0,0) while reset is held.
  always_comb begin
    w_hnext = r_hcount + 10'd1;
    w_vnext = r_vcount;
    if (rst) begin
      w_hnext = '0;
      w_vnext = '0;
    end else if (w_hwrap) begin
      w_hnext = '0;
      w_vnext = w_vwrap ? 10'd0 : r_vcount + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount  <= '0;
      r_vcount  <= '0;
      r_frame   <= '0;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_visible <= 1'b1;
    end else begin
      r_hcount  <= w_hnext;
      r_vcount  <= w_vnext;
      if (w_hwrap && w_vwrap)
        r_frame <= r_frame + 32'd1;
      r_hsync   <= !((w_hnext >= HS_BEG) && (w_hnext < HS_END));
      r_vsync   <= !((w_vnext >= VS_BEG) && (w_vnext < VS_END));
      r_visible <= (w_hnext < H_VIS) && (w_vnext < V_VIS);
    end
  end

  assign position_x      = r_hcount;
  assign position_y      = r_vcount[8:0];
  assign position_x_NEXT = w_hnext;
  assign position_y_NEXT = w_vnext[8:0];
  assign frame           = r_frame;
  assign hsync           = r_hsync;
  assign vsync           = r_vsync;
  assign visible         = r_visible;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: reference-model scoreboard on a narrow-line
// instance plus a default-parameter instance for line timing.
module tb_vga_timing;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 480;
  localparam int VF = 10;
  localparam int VS = 2;
  localparam int VB = 33;
  localparam int VT = VV + VF + VS + VB;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [31:0] f;
    logic        hs;
    logic        vs;
    logic        vis;
    logic [9:0]  xn;
    logic [8:0]  yn;
  } obs_t;

  typedef struct packed {
    int          h;
    int          v;
    logic [31:0] f;
  } st_t;

  logic clk;
  logic rst;

  logic [9:0]  d1_x, d1_xn;
  logic [8:0]  d1_y, d1_yn;
  logic [31:0] d1_f;
  logic        d1_hs, d1_vs, d1_vis;

  logic [9:0]  d2_x, d2_xn;
  logic [8:0]  d2_y, d2_yn;
  logic [31:0] d2_f;
  logic        d2_hs, d2_vs, d2_vis;

  int n_chk;
  int n_pass;
  st_t st;
  obs_t sb[$];

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut1 (
    .clk(clk), .rst(rst),
    .position_x(d1_x), .position_x_NEXT(d1_xn),
    .position_y(d1_y), .position_y_NEXT(d1_yn),
    .frame(d1_f), .hsync(d1_hs), .vsync(d1_vs), .visible(d1_vis)
  );

  vga_timing dut2 (
    .clk(clk), .rst(rst),
    .position_x(d2_x), .position_x_NEXT(d2_xn),
    .position_y(d2_y), .position_y_NEXT(d2_yn),
    .frame(d2_f), .hsync(d2_hs), .vsync(d2_vs), .visible(d2_vis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic st_t step(st_t s);
    st_t n = s;
    if (s.h == HT - 1) begin
      n.h = 0;
      if (s.v == VT - 1) begin
        n.v = 0;
        n.f = s.f + 32'd1;
      end else begin
        n.v = s.v + 1;
      end
    end else begin
      n.h = s.h + 1;
    end
    return n;
  endfunction

  function automatic obs_t expect_of(st_t s);
    obs_t o;
    st_t n = step(s);
    o.x   = 10'(s.h);
    o.y   = s.v[8:0];
    o.f   = s.f;
    o.hs  = !(s.h >= HV + HF && s.h < HV + HF + HS);
    o.vs  = !(s.v >= VV + VF && s.v < VV + VF + VS);
    o.vis = (s.h < HV) && (s.v < VV);
    o.xn  = 10'(n.h);
    o.yn  = n.v[8:0];
    return o;
  endfunction

  // Scoreboard: every tick queues the model's post-edge view of dut1.
  always @(posedge clk) begin : monitor
    obs_t e;
    obs_t o;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      o = {d1_x, d1_y, d1_f, d1_hs, d1_vs, d1_vis, d1_xn, d1_yn};
      n_chk++;
      if (o !== e)
        $display("FAIL scoreboard t=%0t got %h want %h", $time, o, e);
      else
        n_pass++;
    end
  end

  task automatic tick();
    st = step(st);
    sb.push_back(expect_of(st));
    @(negedge clk);
  endtask

  task automatic run_to(input int h, input int v);
    int d;
    d = (v * HT + h) - (st.v * HT + st.h);
    if (d <= 0) d += HT * VT;
    repeat (d) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({d1_x, d1_y} !== 19'd0)
      $display("FAIL rst_pos got %0d,%0d want 0,0", d1_x, d1_y);
    else n_pass++;
    n_chk++;
    if (d1_f !== 32'd0)
      $display("FAIL rst_frame got %0d want 0", d1_f);
    else n_pass++;
    n_chk++;
    if ({d1_hs, d1_vs, d1_vis} !== 3'b111)
      $display("FAIL rst_flags got %b want 111", {d1_hs, d1_vs, d1_vis});
    else n_pass++;
    n_chk++;
    if ({d1_xn, d1_yn} !== 19'd0)
      $display("FAIL rst_next got %0d,%0d want 0,0", d1_xn, d1_yn);
    else n_pass++;
  endtask

  task automatic test_release();
    rst = 1'b0;
    st = '0;
    tick();
    n_chk++;
    if (d1_x !== 10'd1 || d1_y !== 9'd0)
      $display("FAIL release_pos got %0d,%0d want 1,0", d1_x, d1_y);
    else n_pass++;
    n_chk++;
    if (d2_x !== 10'd1 || d2_y !== 9'd0)
      $display("FAIL release_pos2 got %0d,%0d want 1,0", d2_x, d2_y);
    else n_pass++;
  endtask

  task automatic test_line_default();
    int lows = 0;
    int first = -1;
    int vis = 0;
    int nbad = 0;
    int xbad = 0;
    int ex = 1;
    logic [8:0] ywrap = '1;
    logic [9:0] pn = '0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0 && d2_x !== pn) nbad++;
      if (d2_x !== 10'(ex)) xbad++;
      if (!d2_hs) begin
        lows++;
        if (first < 0) first = int'(d2_x);
      end
      if (d2_vis) vis++;
      if (d2_x == 10'd0) ywrap = d2_y;
      pn = d2_xn;
      ex = (ex == 799) ? 0 : ex + 1;
      tick();
    end
    n_chk++;
    if (xbad != 0) $display("FAIL line_x_seq bad=%0d want 0", xbad);
    else n_pass++;
    n_chk++;
    if (nbad != 0) $display("FAIL line_x_next bad=%0d want 0", nbad);
    else n_pass++;
    n_chk++;
    if (ywrap !== 9'd1) $display("FAIL line_y_wrap got %0d want 1", ywrap);
    else n_pass++;
    n_chk++;
    if (lows != 96) $display("FAIL hsync_width got %0d want 96", lows);
    else n_pass++;
    n_chk++;
    if (first != 656) $display("FAIL hsync_start got %0d want 656", first);
    else n_pass++;
    n_chk++;
    if (vis != 640) $display("FAIL visible_width got %0d want 640", vis);
    else n_pass++;
  endtask

  task automatic test_frame();
    int lows = 0;
    int n = 0;
    logic [31:0] f0;
    f0 = d1_f;
    while (d1_f === f0 && n < HT * VT + 10) begin
      if (!d1_vs) lows++;
      tick();
      n++;
    end
    n_chk++;
    if (d1_f !== f0 + 32'd1)
      $display("FAIL frame_step got %0d want %0d", d1_f, f0 + 32'd1);
    else n_pass++;
    n_chk++;
    if (d1_x !== 10'd0 || d1_y !== 9'd0)
      $display("FAIL frame_pos got %0d,%0d want 0,0", d1_x, d1_y);
    else n_pass++;
    n_chk++;
    if (lows != VS * HT)
      $display("FAIL vsync_width got %0d want %0d", lows, VS * HT);
    else n_pass++;
  endtask

  task automatic test_alias();
    int bad = 0;
    logic [31:0] f0;
    run_to(0, 512);
    f0 = d1_f;
    for (int i = 0; i < 13 * HT; i++) begin
      if (d1_y !== 9'(i / HT)) bad++;
      if (d1_vis !== 1'b0 || d1_vs !== 1'b1) bad++;
      if (d1_f !== f0) bad++;
      tick();
    end
    n_chk++;
    if (bad != 0) $display("FAIL alias_lines bad=%0d want 0", bad);
    else n_pass++;
    n_chk++;
    if (d1_f !== f0 + 32'd1)
      $display("FAIL alias_wrap got %0d want %0d", d1_f, f0 + 32'd1);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    while (st.f != 32'd3) tick();
    run_to(5, 200);
    n_chk++;
    if (d1_f !== 32'd3 || d1_x !== 10'd5 || d1_y !== 9'd200)
      $display("FAIL pre_rst got %0d@%0d,%0d want 3@5,200",
               d1_f, d1_x, d1_y);
    else n_pass++;
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    n_chk++;
    if ({d1_x, d1_y, d1_f} !== 51'd0)
      $display("FAIL async_state got %0d,%0d f=%0d want 0,0 f=0",
               d1_x, d1_y, d1_f);
    else n_pass++;
    n_chk++;
    if ({d1_hs, d1_vs, d1_vis, d1_xn, d1_yn} !== {3'b111, 19'd0})
      $display("FAIL async_flags got %b %0d,%0d want 111 0,0",
               {d1_hs, d1_vs, d1_vis}, d1_xn, d1_yn);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    st = '0;
    tick();
    n_chk++;
    if (d1_x !== 10'd1 || d1_y !== 9'd0 || d1_f !== 32'd0)
      $display("FAIL restart got %0d,%0d f=%0d want 1,0 f=0",
               d1_x, d1_y, d1_f);
    else n_pass++;
  endtask

  task automatic test_frame_wrap();
    force dut1.r_frame = 32'hFFFF_FFFF;
    #1;
    release dut1.r_frame;
    st.f = 32'hFFFF_FFFF;
    n_chk++;
    if (d1_f !== 32'hFFFF_FFFF)
      $display("FAIL preset_frame got %h want ffffffff", d1_f);
    else n_pass++;
    run_to(0, 0);
    n_chk++;
    if (d1_f !== 32'd0)
      $display("FAIL frame_wrap got %h want 00000000", d1_f);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    st = '0;
    rst = 1'b1;
    test_reset();
    test_release();
    test_line_default();
    test_frame();
    test_alias();
    test_async_reset();
    test_frame_wrap();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
